// File: rtl/enc_pwm_mixer.sv
// enc_pwm_mixer: NCH rotary-encoder channels, each with synchroniser, debouncer, quadrature
// decoder, saturating level register and PWM output. Define ENC_ACCEL_EN for velocity acceleration.
module enc_pwm_mixer #(
    parameter int NCH          = 3,
    parameter int WIDTH        = 8,
    parameter int DEB_CYCLES   = 4,
    parameter int INIT         = 0,
    parameter int ACCEL_WINDOW = 64,
    parameter int ACCEL_STEP   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       enc_a,
    input  logic [NCH-1:0]       enc_b,
    output logic [NCH-1:0]       pwm_out,
    output logic [NCH*WIDTH-1:0] value_o
);

    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int STW = (($clog2(ACCEL_STEP + 1) > WIDTH) ? $clog2(ACCEL_STEP + 1) : WIDTH) + 1;
    localparam logic [WIDTH-1:0] LVL_MAX  = '1;
    localparam logic [WIDTH-1:0] LVL_INIT = WIDTH'(INIT);
    localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [STW-1:0]   STEP_ONE = STW'(1);

    logic [2*NCH-1:0] sync1_q, sync1_d;
    logic [2*NCH-1:0] sync2_q, sync2_d;
    logic [2*NCH-1:0] deb_q, deb_d;
    logic [DCW-1:0]   deb_cnt_q [2*NCH];
    logic [DCW-1:0]   deb_cnt_d [2*NCH];
    logic [NCH-1:0]   deb_a_prev_q, deb_a_prev_d;
    logic [WIDTH-1:0] level_q [NCH];
    logic [WIDTH-1:0] level_d [NCH];
    logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NCH-1:0]   pwm_q, pwm_d;

    logic [NCH-1:0]   deb_a, deb_b, detent;
    logic [STW-1:0]   step [NCH];

    function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH-1:0] lvl, input logic [STW-1:0] inc);
        logic [31:0] sum;
        sum = 32'(lvl) + 32'(inc);
        return (sum > 32'(LVL_MAX)) ? LVL_MAX : sum[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_dn(input logic [WIDTH-1:0] lvl, input logic [STW-1:0] dec);
        logic [31:0] diff;
        diff = 32'(lvl) - 32'(dec);
        return (32'(dec) > 32'(lvl)) ? '0 : diff[WIDTH-1:0];
    endfunction

    // A phases occupy the low NCH bits of every synchroniser/debounce vector, B phases the high bits.
    always_comb begin
        sync1_d = {enc_b, enc_a};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int k = 0; k < 2*NCH; k++) begin
            deb_cnt_d[k] = deb_cnt_q[k];
            if (sync2_q[k] == deb_q[k]) begin
                deb_cnt_d[k] = '0;
            end else if (deb_cnt_q[k] == DEB_LAST) begin
                deb_d[k]     = sync2_q[k];
                deb_cnt_d[k] = '0;
            end else begin
                deb_cnt_d[k] = deb_cnt_q[k] + DCW'(1);
            end
        end
    end

    assign deb_a        = deb_q[NCH-1:0];
    assign deb_b        = deb_q[2*NCH-1:NCH];
    assign detent       = deb_a & ~deb_a_prev_q;
    assign deb_a_prev_d = deb_a;

`ifdef ENC_ACCEL_EN
    localparam int GW = $clog2(ACCEL_WINDOW) + 1;
    localparam logic [GW-1:0]  GAP_MAX   = '1;
    localparam logic [GW-1:0]  GAP_WIN   = GW'(ACCEL_WINDOW);
    localparam logic [STW-1:0] STEP_FAST = STW'(ACCEL_STEP);

    logic [GW-1:0] gap_q [NCH];
    logic [GW-1:0] gap_d [NCH];

    // Gap counters start saturated so the first detent after reset is never accelerated.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            step[i] = (gap_q[i] < GAP_WIN) ? STEP_FAST : STEP_ONE;
            if (detent[i]) begin
                gap_d[i] = '0;
            end else if (gap_q[i] == GAP_MAX) begin
                gap_d[i] = gap_q[i];
            end else begin
                gap_d[i] = gap_q[i] + GW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) gap_q[i] <= GAP_MAX;
        end else begin
            for (int i = 0; i < NCH; i++) gap_q[i] <= gap_d[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NCH; i++) step[i] = STEP_ONE;
    end
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            level_d[i] = level_q[i];
            if (detent[i]) begin
                level_d[i] = deb_b[i] ? sat_dn(level_q[i], step[i]) : sat_up(level_q[i], step[i]);
            end
        end
    end

    // Shared free-running counter; the compare is registered, so pwm_out lags by one cycle.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + WIDTH'(1);
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = (pwm_cnt_q < level_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_a_prev_q <= '0;
            for (int k = 0; k < 2*NCH; k++) deb_cnt_q[k] <= '0;
            for (int i = 0; i < NCH; i++) level_q[i] <= LVL_INIT;
            pwm_cnt_q    <= '0;
            pwm_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_a_prev_q <= deb_a_prev_d;
            for (int k = 0; k < 2*NCH; k++) deb_cnt_q[k] <= deb_cnt_d[k];
            for (int i = 0; i < NCH; i++) level_q[i] <= level_d[i];
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_q        <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

    always_comb begin
        value_o = '0;
        for (int i = 0; i < NCH; i++) begin
            value_o[i*WIDTH +: WIDTH] = level_q[i];
        end
    end

endmodule

// File: doc/enc_pwm_mixer.md
# enc_pwm_mixer

Parametrised successor to the three-channel RGB mixer: NCH independent rotary-encoder channels, each with synchroniser, debouncer, quadrature decoder, saturating WIDTH-bit level register and PWM output. Sits directly behind the encoder input pins and drives LED/PWM pins. Adds configurable channel count, PWM resolution, debounce length, saturation instead of wrap, exported level values, and optional velocity acceleration.

## Interface
- NCH, 3: number of encoder/PWM channels (1..8).
- WIDTH, 8: level and PWM counter width (4..12).
- DEB_CYCLES, 4: consecutive stable synchronised cycles needed to accept a new encoder level (>=1).
- INIT, 0: reset value of every level register (< 2^WIDTH).
- ACCEL_WINDOW, 64: detent gap in cycles below which acceleration applies (ENC_ACCEL_EN only).
- ACCEL_STEP, 4: step per detent when accelerated (ENC_ACCEL_EN only).

- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- enc_a  in  NCH  encoder A phases, asynchronous to clk.
- enc_b  in  NCH  encoder B phases, asynchronous to clk.
- pwm_out  out  NCH  registered PWM outputs.
- value_o  out  NCH*WIDTH  level registers; channel i at bits [i*WIDTH +: WIDTH].

## Operation
- Reset (async, while high): sync flops, debounced levels, debounce counters, edge history to 0; level registers to INIT; PWM counter to 0; pwm_out to 0; value_o to INIT; accel gap counters to saturated maximum.
- Synchroniser: two flops per enc_a/enc_b bit.
- Debounce per bit: counter clears whenever synced input equals debounced level; otherwise increments; when counter == DEB_CYCLES-1 and input still differs, debounced level takes input, counter clears. Pulses shorter than DEB_CYCLES cycles never propagate.
- Decoder: detent = rising edge of debounced A (deb_a & ~deb_a_prev). Debounced B == 0 at detent: increment; B == 1: decrement. Falling A ignored.
- Level: saturating; increment clamps at 2^WIDTH-1, decrement clamps at 0. No wrap. Step size 1 (or per ENC_ACCEL_EN).
- Channels fully independent; simultaneous detents on different channels all apply in the same cycle.
- PWM: one shared free-running WIDTH-bit counter, wraps 2^WIDTH-1 -> 0. pwm_out[i] registered as (counter < level[i]). Level 0 -> constant low; level 2^WIDTH-1 -> high 2^WIDTH-1 of every 2^WIDTH cycles.
- Level change mid-period takes effect on next compare; no period restart.

## Timing
- Edge 1 = first clk edge sampling the new pin level. Debounced A changes at edge DEB_CYCLES+2; value_o changes at edge DEB_CYCLES+3; pwm_out reflects new level from edge DEB_CYCLES+4.
- Max one detent per channel per DEB_CYCLES+1 cycles; faster pin toggling is filtered, not queued.
- PWM period exactly 2^WIDTH cycles; pwm_out lags compare by one cycle.
- Reset mid-operation: all outputs reach reset values immediately (async), no clock needed; operation resumes on first edge after release, counter from 0.

## Configuration
- ENC_ACCEL_EN defined: per-channel saturating gap counter, clog2(ACCEL_WINDOW)+1 bits, increments every cycle, clears on detent. At detent, gap < ACCEL_WINDOW -> step ACCEL_STEP, else step 1. Saturation clamps as above (e.g. 253 + 4 -> 255, 2 - 4 -> 0). First detent after reset always step 1.
- ENC_ACCEL_EN undefined: step always 1; no gap counters; ACCEL_* parameters unused.

## Test plan
- Reset with NCH=3, WIDTH=8, INIT=0; hold 300 cycles after release, inputs idle -> value_o=0, pwm_out=0 throughout.
- Five clockwise detents on channel 0 (B=0 at A rise), 200 cycles apart -> value_o[7:0]=5, channels 1/2 =0; pwm_out[0] high exactly 5 of every 256 cycles; first value change at edge DEB_CYCLES+3 after A rise.
- Channel 1: one CCW detent at level 0 -> stays 0; then 260 CW detents (spaced 200) -> 255, pwm_out[1] high 255/256 cycles.
- 3-cycle high glitch on enc_a[2] with DEB_CYCLES=4 -> no level change; 4-cycle pulse -> +1.
- ENC_ACCEL_EN, ACCEL_WINDOW=64, ACCEL_STEP=4: CW detents 20 cycles... spaced DEB_CYCLES-compliant 30 cycles apart ×3 on channel 0 -> 1, 5, 9; then detent after 100-cycle gap -> 10.
- Simultaneous CW detents on channels 0 and 2 with level 50 on both; reset asserted mid-PWM-period -> both reach 51 same cycle; on reset all pwm_out=0, value_o=0 without clock edge.
